bnn_param_loader: RTL and testbench

Upstream configuration stage for the tiny BNN neuron array. It accepts weight/bias parameters as 4-bit nibbles over a valid/ready handshake and serializes them MSB-first onto the neuron parameter shift chain. It drives the chain's `setup` and serial `param_in` so that exactly `PARAM_BITS` bits are clocked in. It then signals completion. The nibble source is typically the pad-level nibble bus already used for `x`.

---
 rtl/bnn_param_loader.sv | 133 +++++++++++++
 tb/tb_bnn_param_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_param_loader.sv
// Nibble-to-serial loader for the BNN neuron parameter shift chain (MSB-first).
// Optional running-parity output is enabled by defining BNN_LOADER_PARITY_EN.
module bnn_param_loader #(
    parameter  int PARAM_BITS = 72,
    localparam int CNT_W      = $clog2(PARAM_BITS + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    output logic       nib_ready,
    output logic       setup,
    output logic       param_out,
    output logic       busy,
`ifdef BNN_LOADER_PARITY_EN
    output logic       done,
    output logic       parity
`else
    output logic       done
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(PARAM_BITS);
    localparam logic [CNT_W-1:0] BITS_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [3:0]       shreg_q, shreg_d;
    logic [1:0]       sub_q, sub_d;
`ifdef BNN_LOADER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            shreg_q     <= 4'h0;
            sub_q       <= 2'd0;
`ifdef BNN_LOADER_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            shreg_q     <= shreg_d;
            sub_q       <= sub_d;
`ifdef BNN_LOADER_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        shreg_d     = shreg_q;
        sub_d       = sub_q;
`ifdef BNN_LOADER_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD;
                    bits_left_d = BITS_FULL;
`ifdef BNN_LOADER_PARITY_EN
                    parity_d    = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                // Abort takes priority so a coincident nibble is never consumed
                if (abort) begin
                    state_d = IDLE;
                end else if (nib_valid) begin
                    shreg_d = nib_data;
                    sub_d   = 2'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = LOAD;
                end
            end
            SHIFT: begin
                shreg_d     = {shreg_q[2:0], 1'b0};
                sub_d       = sub_q + 2'd1;
                bits_left_d = bits_left_q - BITS_ONE;
`ifdef BNN_LOADER_PARITY_EN
                parity_d    = parity_q ^ shreg_q[3];
`endif
                // Reaching the last chain bit drops any unshifted nibble remainder
                if (abort) begin
                    state_d = IDLE;
                end else if (bits_left_q == BITS_ONE) begin
                    state_d = DONE;
                end else if (sub_q == 2'd3) begin
                    state_d = LOAD;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign nib_ready = (state_q == LOAD);
    assign setup     = (state_q == SHIFT);
    assign param_out = (state_q == SHIFT) & shreg_q[3];
    assign busy      = (state_q == LOAD) | (state_q == SHIFT);
    assign done      = (state_q == DONE);
`ifdef BNN_LOADER_PARITY_EN
    assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed self-checking bench for bnn_param_loader: three instances with
// PARAM_BITS of 8, 6 and 72 (parity checks only when BNN_LOADER_PARITY_EN is set).
module tb_bnn_param_loader;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_s;
    logic [2:0] abort_s;
    logic [2:0] nib_valid_s;
    logic [3:0] nib_data_s [3];
    logic [2:0] nib_ready_w;
    logic [2:0] setup_w;
    logic [2:0] param_out_w;
    logic [2:0] busy_w;
    logic [2:0] done_w;
`ifdef BNN_LOADER_PARITY_EN
    logic [2:0] parity_w;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bnn_param_loader #(.PARAM_BITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .nib_valid(nib_valid_s[0]), .nib_data(nib_data_s[0]),
        .nib_ready(nib_ready_w[0]), .setup(setup_w[0]), .param_out(param_out_w[0]),
        .busy(busy_w[0]),
`ifdef BNN_LOADER_PARITY_EN
        .parity(parity_w[0]),
`endif
        .done(done_w[0])
    );

    bnn_param_loader #(.PARAM_BITS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .nib_valid(nib_valid_s[1]), .nib_data(nib_data_s[1]),
        .nib_ready(nib_ready_w[1]), .setup(setup_w[1]), .param_out(param_out_w[1]),
        .busy(busy_w[1]),
`ifdef BNN_LOADER_PARITY_EN
        .parity(parity_w[1]),
`endif
        .done(done_w[1])
    );

    bnn_param_loader u_dut72 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .abort(abort_s[2]),
        .nib_valid(nib_valid_s[2]), .nib_data(nib_data_s[2]),
        .nib_ready(nib_ready_w[2]), .setup(setup_w[2]), .param_out(param_out_w[2]),
        .busy(busy_w[2]),
`ifdef BNN_LOADER_PARITY_EN
        .parity(parity_w[2]),
`endif
        .done(done_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int sel, input string tag);
        check_eq({tag, "_ready"}, 72'(nib_ready_w[sel]), 72'd0);
        check_eq({tag, "_setup"}, 72'(setup_w[sel]), 72'd0);
        check_eq({tag, "_pout"},  72'(param_out_w[sel]), 72'd0);
        check_eq({tag, "_busy"},  72'(busy_w[sel]), 72'd0);
        check_eq({tag, "_done"},  72'(done_w[sel]), 72'd0);
    endtask

    task automatic do_start(input int sel);
        start_s[sel] = 1'b1;
        tick();
        start_s[sel] = 1'b0;
        check_eq("start_busy",  72'(busy_w[sel]), 72'd1);
        check_eq("start_ready", 72'(nib_ready_w[sel]), 72'd1);
    endtask

    // Zero-stall source feeding nibbles; captures bits while setup is high
    task automatic run_load(input int sel, input logic [71:0] nibvec, input int nnib,
                            input logic [71:0] exp_bits, input int nbits,
                            input int exp_ticks, input bit poke_start);
        int          k      = 0;
        int          ticks  = 0;
        int          nset   = 0;
        logic [71:0] got    = '0;
        logic [71:0] tmp;
        bit          prev_setup = 1'b0;
        bit          seen_done  = 1'b0;
        bit          hs;
        while (!seen_done && ticks < 500) begin
            hs  = nib_ready_w[sel] && (k < nnib);
            tmp = nibvec >> (4 * (nnib - 1 - k));
            nib_valid_s[sel] = hs;
            nib_data_s[sel]  = hs ? tmp[3:0] : 4'h0;
            start_s[sel]     = poke_start && hs && (k == nnib / 2);
            tick();
            ticks++;
            nib_valid_s[sel] = 1'b0;
            start_s[sel]     = 1'b0;
            if (hs) k++;
            if (setup_w[sel]) begin
                got = {got[70:0], param_out_w[sel]};
                nset++;
            end
            if (done_w[sel]) begin
                seen_done = 1'b1;
                check_eq("done_after_setup", 72'(prev_setup), 72'd1);
            end
            prev_setup = setup_w[sel];
        end
        check_eq("done_seen",   72'(seen_done), 72'd1);
        check_eq("setup_count", 72'(nset), 72'(nbits));
        check_eq("bits",        got, exp_bits);
        check_eq("load_cycles", 72'(ticks), 72'(exp_ticks));
        tick();
        check_idle(sel, "after_done");
    endtask

    initial begin
        rst_n       = 1'b0;
        start_s     = 3'b000;
        abort_s     = 3'b000;
        nib_valid_s = 3'b000;
        for (int i = 0; i < 3; i++) nib_data_s[i] = 4'h0;
        #12;
        for (int i = 0; i < 3; i++) check_idle(i, "reset");
        rst_n = 1'b1;
        tick();

        // Two nibbles 0xA, 0x5 into an 8-bit chain
        do_start(0);
        run_load(0, 72'hA5, 2, 72'hA5, 8, 10, 1'b0);

        // Truncation: 0xF, 0x3 into a 6-bit chain gives 111100
        do_start(1);
        run_load(1, 72'hF3, 2, 72'h3C, 6, 8, 1'b0);

        // Backpressure: 10 idle cycles in LOAD, then normal completion
        do_start(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_ready", 72'(nib_ready_w[0]), 72'd1);
            check_eq("bp_setup", 72'(setup_w[0]), 72'd0);
            check_eq("bp_busy",  72'(busy_w[0]), 72'd1);
        end
        run_load(0, 72'h5A, 2, 72'h5A, 8, 10, 1'b0);

        // Abort in second SHIFT cycle of the first nibble
        do_start(0);
        nib_valid_s[0] = 1'b1;
        nib_data_s[0]  = 4'hA;
        tick();
        nib_valid_s[0] = 1'b0;
        check_eq("ab_bit0", 72'(param_out_w[0]), 72'd1);
        tick();
        check_eq("ab_setup2", 72'(setup_w[0]), 72'd1);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        check_idle(0, "abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("abort_no_done", 72'(done_w[0]), 72'd0);
        end
        do_start(0);
        run_load(0, 72'hC3, 2, 72'hC3, 8, 10, 1'b0);

        // Abort coincident with a handshake: nibble not consumed
        do_start(0);
        abort_s[0]     = 1'b1;
        nib_valid_s[0] = 1'b1;
        nib_data_s[0]  = 4'hF;
        tick();
        abort_s[0]     = 1'b0;
        nib_valid_s[0] = 1'b0;
        check_idle(0, "abort_hs");
        do_start(0);
        run_load(0, 72'h81, 2, 72'h81, 8, 10, 1'b0);

        // Asynchronous reset during SHIFT while param_out is 1
        do_start(0);
        nib_valid_s[0] = 1'b1;
        nib_data_s[0]  = 4'hB;
        tick();
        nib_valid_s[0] = 1'b0;
        check_eq("rst_pre_pout", 72'(param_out_w[0]), 72'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle(0, "async_rst");
        #3 rst_n = 1'b1;
        tick();
        check_idle(0, "post_rst_nostart");
        do_start(0);
        run_load(0, 72'hB4, 2, 72'hB4, 8, 10, 1'b0);

        // Full 72-bit loads; start poked in LOAD mid-way must not reload
        do_start(2);
        run_load(2, 72'h777777777777777777, 18, 72'h777777777777777777, 72, 90, 1'b0);
`ifdef BNN_LOADER_PARITY_EN
        check_eq("parity_7s", 72'(parity_w[2]), 72'd0);
`endif
        do_start(2);
        run_load(2, 72'h777777777777777773, 18, 72'h777777777777777773, 72, 90, 1'b1);
`ifdef BNN_LOADER_PARITY_EN
        check_eq("parity_last3", 72'(parity_w[2]), 72'd1);
        tick();
        check_eq("parity_hold", 72'(parity_w[2]), 72'd1);
`endif
        do_start(2);
`ifdef BNN_LOADER_PARITY_EN
        check_eq("parity_clear", 72'(parity_w[2]), 72'd0);
`endif
        run_load(2, 72'h777777777777777777, 18, 72'h777777777777777777, 72, 90, 1'b0);
`ifdef BNN_LOADER_PARITY_EN
        check_eq("parity_7s_again", 72'(parity_w[2]), 72'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
